// File: rtl/prism_cfg_seq_if.sv
// Bundled host, table, sequencer and PRISM debug-port signals for prism_cfg_seq.
// The master side drives requests; the slave side is the sequencer.
interface prism_cfg_seq_if #(parameter int IW = 3);
  logic [5:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_wr;
  logic        tbl_we;
  logic [IW-1:0] tbl_idx;
  logic [5:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic        start;
  logic [IW:0] count;
  logic        abort;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_wr;
  logic        fsm_reset;
  logic        fsm_enable;
  logic        busy;
  logic        done;
  logic        err;
  logic        stall;

  modport master (
    output host_addr, host_wdata, host_wr, tbl_we, tbl_idx, tbl_addr, tbl_data,
           start, count, abort,
    input  dbg_addr, dbg_wdata, dbg_wr, fsm_reset, fsm_enable, busy, done, err, stall
  );
  modport slave (
    input  host_addr, host_wdata, host_wr, tbl_we, tbl_idx, tbl_addr, tbl_data,
           start, count, abort,
    output dbg_addr, dbg_wdata, dbg_wr, fsm_reset, fsm_enable, busy, done, err, stall
  );
endinterface

// File: rtl/prism_cfg_seq.sv
// PRISM configuration sequencer: halts the FSM, streams staged (addr,data) entries
// onto the shared debug write port, then re-enables it. Host writes always win the port.
module prism_cfg_seq #(
  parameter int DEPTH = 8,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  prism_cfg_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HALT, LOAD, RELEASE} state_t;

  localparam int          NE      = 1 << IW;
  localparam logic [IW:0] DEPTH_C = (IW+1)'(DEPTH);

  logic [5:0]  tbl_a [NE];
  logic [31:0] tbl_d [NE];

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic          fr_q, fr_d, fe_q, fe_d, err_q, err_d;
  logic          seq_wr, last, cnt_ok;

  // Table has no reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (bus.tbl_we && state_q == IDLE && {1'b0, bus.tbl_idx} < DEPTH_C) begin
      tbl_a[bus.tbl_idx] <= bus.tbl_addr;
      tbl_d[bus.tbl_idx] <= bus.tbl_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      fr_q    <= 1'b0;
      fe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fr_q    <= fr_d;
      fe_q    <= fe_d;
      err_q   <= err_d;
    end
  end

  assign cnt_ok = (bus.count != '0) && (bus.count <= DEPTH_C);
  assign last   = ({1'b0, idx_q} == cnt_q - (IW+1)'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    fr_d    = fr_q;
    fe_d    = fe_q;
    err_d   = 1'b0;
    seq_wr  = 1'b0;
    if (bus.tbl_we && state_q != IDLE) err_d = 1'b1;
    if (state_q == IDLE) begin
      if (!bus.abort && bus.start) begin
        if (cnt_ok) begin
          state_d = HALT;
          cnt_d   = bus.count;
          idx_d   = '0;
          fr_d    = 1'b1;
          fe_d    = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (bus.abort) begin
      // Leave PRISM held in reset; nothing further reaches the port.
      state_d = IDLE;
      fr_d    = 1'b1;
      fe_d    = 1'b0;
    end else begin
      if (bus.start) err_d = 1'b1;
      case (state_q)
        HALT: state_d = LOAD;
        LOAD: begin
          if (!bus.host_wr) begin
            seq_wr = 1'b1;
            idx_d  = idx_q + 1'b1;
            if (last) begin
              state_d = RELEASE;
              fr_d    = 1'b0;
              fe_d    = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.dbg_wr     = bus.host_wr | seq_wr;
  assign bus.dbg_addr   = bus.host_wr ? bus.host_addr  : tbl_a[idx_q];
  assign bus.dbg_wdata  = bus.host_wr ? bus.host_wdata : tbl_d[idx_q];
  assign bus.fsm_reset  = fr_q;
  assign bus.fsm_enable = fe_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == RELEASE);
  assign bus.err        = err_q;
  assign bus.stall      = (state_q == LOAD) && bus.host_wr && !bus.abort;
endmodule

// File: tb/tb_prism_cfg_seq.sv
// Directed per-cycle vectors for prism_cfg_seq (DEPTH=8); inputs applied on the falling
// edge, outputs of that cycle compared 1ns later.
module tb_prism_cfg_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prism_cfg_seq_if #(.IW(3)) bus ();
  prism_cfg_seq #(.DEPTH(8), .IW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        rst;
    logic        host_wr;
    logic [5:0]  host_addr;
    logic [31:0] host_wdata;
    logic        tbl_we;
    logic [2:0]  tbl_idx;
    logic [5:0]  tbl_addr;
    logic [31:0] tbl_data;
    logic        start;
    logic [3:0]  count;
    logic        abort;
  } in_t;

  typedef struct packed {
    logic        fr;
    logic        fe;
    logic        busy;
    logic        done;
    logic        err;
    logic        stall;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic in_t nop();
    in_t r = '0;
    return r;
  endfunction
  function automatic in_t rs();
    in_t r = '0; r.rst = 1'b1; return r;
  endfunction
  function automatic in_t hw(input logic [5:0] a, input logic [31:0] d);
    in_t r = '0; r.host_wr = 1'b1; r.host_addr = a; r.host_wdata = d; return r;
  endfunction
  function automatic in_t twe(input logic [2:0] k, input logic [5:0] a, input logic [31:0] d);
    in_t r = '0; r.tbl_we = 1'b1; r.tbl_idx = k; r.tbl_addr = a; r.tbl_data = d; return r;
  endfunction
  function automatic in_t st(input logic [3:0] c);
    in_t r = '0; r.start = 1'b1; r.count = c; return r;
  endfunction
  function automatic in_t ab();
    in_t r = '0; r.abort = 1'b1; return r;
  endfunction

  function automatic out_t o(input bit fr, input bit fe, input bit bsy,
                             input bit dn = 0, input bit er = 0, input bit stl = 0);
    out_t r = '0;
    r.fr = fr; r.fe = fe; r.busy = bsy; r.done = dn; r.err = er; r.stall = stl;
    return r;
  endfunction
  function automatic out_t w(input out_t b, input logic [5:0] a, input logic [31:0] d);
    out_t r = b; r.wr = 1'b1; r.addr = a; r.data = d; return r;
  endfunction

  task automatic drive(input in_t x);
    rst            = x.rst;
    bus.host_wr    = x.host_wr;
    bus.host_addr  = x.host_addr;
    bus.host_wdata = x.host_wdata;
    bus.tbl_we     = x.tbl_we;
    bus.tbl_idx    = x.tbl_idx;
    bus.tbl_addr   = x.tbl_addr;
    bus.tbl_data   = x.tbl_data;
    bus.start      = x.start;
    bus.count      = x.count;
    bus.abort      = x.abort;
  endtask

  task automatic check(input string nm, input out_t e);
    out_t g;
    g.fr = bus.fsm_reset; g.fe = bus.fsm_enable; g.busy = bus.busy; g.done = bus.done;
    g.err = bus.err; g.stall = bus.stall; g.wr = bus.dbg_wr;
    g.addr = bus.dbg_addr; g.data = bus.dbg_wdata;
    if (e.wr !== 1'b1) begin
      g.addr = '0; g.data = '0; e.addr = '0; e.data = '0;
    end
    n_vec++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s got fr%b fe%b bsy%b dn%b er%b stl%b wr%b %h/%h exp fr%b fe%b bsy%b dn%b er%b stl%b wr%b %h/%h",
               nm, g.fr, g.fe, g.busy, g.done, g.err, g.stall, g.wr, g.addr, g.data,
               e.fr, e.fe, e.busy, e.done, e.err, e.stall, e.wr, e.addr, e.data);
    end
  endtask

  task automatic step(input in_t x);
    @(negedge clk);
    drive(x);
    #1;
  endtask

  initial begin
    out_t ld;
    int   lat;
    // passthrough during reset, then table loads
    vq.push_back('{rs() | hw(6'h11, 32'hDEAD0001), w(o(0,0,0), 6'h11, 32'hDEAD0001)});
    vq.push_back('{nop(),                     o(0,0,0)});
    vq.push_back('{twe(0, 6'h04, 32'hA5A5A5A5), o(0,0,0)});
    vq.push_back('{twe(1, 6'h08, 32'h00000001), o(0,0,0)});
    vq.push_back('{twe(2, 6'h0C, 32'hFFFF0000), o(0,0,0)});
    // basic count=3 run
    ld = o(1,0,1);
    vq.push_back('{st(3), o(0,0,0)});
    vq.push_back('{nop(), ld});
    vq.push_back('{nop(), w(ld, 6'h04, 32'hA5A5A5A5)});
    vq.push_back('{nop(), w(ld, 6'h08, 32'h00000001)});
    vq.push_back('{nop(), w(ld, 6'h0C, 32'hFFFF0000)});
    vq.push_back('{nop(), o(0,1,1,1)});
    vq.push_back('{nop(), o(0,1,0)});
    // host contention at T+3
    vq.push_back('{st(3), o(0,1,0)});
    vq.push_back('{nop(), ld});
    vq.push_back('{nop(), w(ld, 6'h04, 32'hA5A5A5A5)});
    vq.push_back('{hw(6'h00, 32'h20000000), w(o(1,0,1,0,0,1), 6'h00, 32'h20000000)});
    vq.push_back('{nop(), w(ld, 6'h08, 32'h00000001)});
    vq.push_back('{nop(), w(ld, 6'h0C, 32'hFFFF0000)});
    vq.push_back('{nop(), o(0,1,1,1)});
    vq.push_back('{nop(), o(0,1,0)});
    // illegal starts, start while busy, tbl_we while busy
    vq.push_back('{st(0), o(0,1,0)});
    vq.push_back('{nop(), o(0,1,0,0,1)});
    vq.push_back('{st(9), o(0,1,0)});
    vq.push_back('{nop(), o(0,1,0,0,1)});
    vq.push_back('{st(2), o(0,1,0)});
    vq.push_back('{st(2), ld});
    vq.push_back('{twe(0, 6'h3F, 32'h00000BAD), w(o(1,0,1,0,1), 6'h04, 32'hA5A5A5A5)});
    vq.push_back('{nop(), w(o(1,0,1,0,1), 6'h08, 32'h00000001)});
    vq.push_back('{nop(), o(0,1,1,1)});
    vq.push_back('{nop(), o(0,1,0)});
    // abort at T+4 of a count=8 run: entries 0,1 only
    vq.push_back('{st(8), o(0,1,0)});
    vq.push_back('{nop(), ld});
    vq.push_back('{nop(), w(ld, 6'h04, 32'hA5A5A5A5)});
    vq.push_back('{nop(), w(ld, 6'h08, 32'h00000001)});
    vq.push_back('{ab(),  ld});
    vq.push_back('{nop(), o(1,0,0)});
    vq.push_back('{nop(), o(1,0,0)});
    // abort and start together in idle
    vq.push_back('{st(3) | ab(), o(1,0,0)});
    vq.push_back('{nop(), o(1,0,0)});
    vq.push_back('{nop(), o(1,0,0)});

    drive(rs());
    repeat (2) @(posedge clk);
    foreach (vq[k]) begin
      step(vq[k].i);
      check($sformatf("vec%0d", k), vq[k].e);
    end

    // mid-sequence reset at T+3 of a count=4 run
    step(st(4)); check("mr_start", o(1,0,0));
    step(nop()); check("mr_halt", ld);
    step(nop()); check("mr_ld0", w(ld, 6'h04, 32'hA5A5A5A5));
    step(rs());  check("mr_ld1", w(ld, 6'h08, 32'h00000001));
    step(nop()); check("mr_after", o(0,0,0));
    // fresh start after reset; done must come 3 cycles later for count=1
    step(st(1)); check("fr_start", o(0,0,0));
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      step(nop());
      if (bus.done === 1'b1) begin lat = c; break; end
    end
    n_vec++;
    if (lat != 3) begin
      n_bad++;
      $display("FAIL fr_latency got %0d exp 3 (0 = no done within budget)", lat);
    end
    step(nop()); check("fr_idle", o(0,1,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/prism_cfg_seq.md
PRISM_CFG_SEQ -- requirements
Module: prism_cfg_seq

Interface
REQ-001 Parameter DEPTH, default 8: number of staged configuration entries; legal values 2..16.
REQ-002 Parameter IW, default 3: table index width, equal to clog2(DEPTH).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 host_addr  in  6  host debug-port address.
REQ-006 host_wdata  in  32  host debug-port write data.
REQ-007 host_wr  in  1  host debug-port write strobe; always has priority on the shared port.
REQ-008 tbl_we  in  1  table write strobe.
REQ-009 tbl_idx  in  IW  table entry to write.
REQ-010 tbl_addr  in  6  debug address stored in the entry.
REQ-011 tbl_data  in  32  debug data stored in the entry.
REQ-012 start  in  1  one-cycle pulse that launches a load sequence.
REQ-013 count  in  IW+1  number of entries to stream; sampled on start.
REQ-014 abort  in  1  one-cycle pulse that cancels the sequence.
REQ-015 dbg_addr, dbg_wdata, dbg_wr  out  6/32/1  shared PRISM debug write port.
REQ-016 fsm_reset  out  1  PRISM debug_reset, registered.
REQ-017 fsm_enable  out  1  PRISM fsm_enable, registered.
REQ-018 busy  out  1  high in every non-IDLE state.
REQ-019 done  out  1  one-cycle completion pulse.
REQ-020 err  out  1  one-cycle illegal-request pulse.
REQ-021 stall  out  1  high when the sequencer holds a pending write that host_wr has blocked.

Function
REQ-022 The block SHALL have four states: IDLE, HALT, LOAD and RELEASE.
REQ-023 Start handling: a start in IDLE with 1 <= count <= DEPTH and no abort SHALL latch count, clear the index to 0 and go to HALT. Any other start SHALL raise err for one cycle and leave the state and outputs unchanged.
REQ-024 Conditions that make a start illegal: count = 0, count > DEPTH, or the block not in IDLE.
REQ-025 Entering HALT SHALL set fsm_reset=1 and fsm_enable=0. HALT lasts exactly one cycle, then goes to LOAD.
REQ-026 LOAD issue: each LOAD cycle with host_wr=0 SHALL drive dbg_wr=1 with table[index], then increment the index.
REQ-027 LOAD exit: once the write for index count-1 has been issued, the next state SHALL be RELEASE.
REQ-028 LOAD with host_wr=1: the cycle SHALL pass the host access through, assert stall, and hold the index.
REQ-029 Port mux: when host_wr=1, dbg_* SHALL equal host_*, combinationally and in every state.
REQ-030 When neither the host nor the sequencer writes, dbg_wr SHALL be 0. dbg_addr and dbg_wdata are then don't-care.
REQ-031 Entering RELEASE SHALL set fsm_reset=0 and fsm_enable=1. done SHALL be high during the RELEASE cycle only, and the next state is IDLE.
REQ-032 fsm_enable and fsm_reset SHALL hold their values in IDLE until the next start or abort.
REQ-033 An abort in any non-IDLE state SHALL go to IDLE next cycle with fsm_reset=1, fsm_enable=0, done=0 and no further table writes issued.
REQ-034 An abort in IDLE SHALL have no effect.
REQ-035 If abort and start arrive in the same cycle, abort SHALL win: no sequence starts and err stays 0.
REQ-036 A tbl_we in IDLE SHALL write the entry at the edge. A tbl_we while busy SHALL be ignored and raise err.
REQ-037 Table contents SHALL NOT be reset.
REQ-038 With no host contention, total sequence latency SHALL be count+2 cycles of busy: HALT + count LOAD cycles + RELEASE.

Reset
REQ-039 While rst=1 at a clock edge, the block SHALL enter IDLE with fsm_reset=0, fsm_enable=0, busy=0, done=0, err=0, stall=0 and index=0. This includes reset in the middle of a sequence.
REQ-040 The dbg_* passthrough of host_* SHALL remain functional during reset.

Verification
REQ-041 Basic sequence: load entries 0..2 = (0x04,0xA5A5A5A5), (0x08,0x1), (0x0C,0xFFFF0000), then start with count=3 at cycle T. Required: HALT at T+1 (fsm_reset=1); dbg writes in that order at T+2..T+4; done=1 and fsm_enable=1 at T+5; busy=0 at T+6.
REQ-042 Host contention: same setup with host_wr=1 (addr 0x00, data 0x20000000) at T+3. Required: the host word appears at T+3 with stall=1; entry 1 moves to T+4; done at T+6.
REQ-043 Illegal starts: start with count=0, then with count=DEPTH+1, then start while busy, then tbl_we while busy. Required: err pulses each time; state, outputs and table unchanged.
REQ-044 Abort: start with count=8 and abort at T+4. Required: at T+5 the state is IDLE, fsm_reset=1, fsm_enable=0, no done pulse, and exactly 2 table writes issued.
REQ-045 Mid-sequence reset: rst=1 at T+3 of a count=4 run. Required: next cycle all outputs at reset values, and a fresh start succeeds.
REQ-046 Abort and start together in IDLE: pulse both in the same cycle. Required: the block stays in IDLE and err=0.
